// File: rtl/dec8_pkg.sv
// Shared types and helpers for the dec8_strobe one-hot strobe generator.
package dec8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width of the pulse/gap down-counter; wide enough for lengths up to 255.
  localparam int CNT_W = 8;

  // Turns a 3-bit index into the matching one-hot byte.
  function automatic logic [7:0] onehot8(input logic [2:0] code);
    onehot8 = 8'b0000_0001 << code;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero when disabled.
module dec3to8
  import dec8_pkg::*;
(
  input  logic [2:0] i_code,
  input  logic       i_en,
  output logic [7:0] o_onehot
);

  // Gate the decoded index so the strobe register loads zero outside PULSE.
  always_comb begin
    o_onehot = 8'h00;
    if (i_en) begin
      o_onehot = onehot8(i_code);
    end
  end

endmodule

// File: rtl/dec8_strobe.sv
// Accepts a 3-bit index under valid/ready, then drives the matching one-hot
// strobe for PULSE_LEN cycles followed by GAP_LEN forced-idle cycles.
module dec8_strobe
  import dec8_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  // Reject lengths the 8-bit counter cannot represent, and a zero-length pulse.
  if (PULSE_LEN < 1 || PULSE_LEN > 255 || GAP_LEN < 0 || GAP_LEN > 255) begin : g_badParams
    $error("dec8_strobe: PULSE_LEN must be 1..255 and GAP_LEN 0..255");
  end

  // Counter preload values: the counter holds "cycles remaining after this one".
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_code;
  logic [7:0]       r_out;
  logic             r_outValid;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCount;
  logic [2:0]       w_nextCode;
  logic [7:0]       w_onehot;

  // Next-state, counter and code-latch logic; abort overrides everything.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextCode  = r_code;
    if (abort) begin
      w_nextState = IDLE;
      w_nextCount = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_nextState = PULSE;
            w_nextCount = PULSE_LOAD;
            w_nextCode  = in;
          end
        end
        PULSE: begin
          if (r_count == '0) begin
            if (GAP_LEN == 0) begin
              w_nextState = IDLE;
              w_nextCount = '0;
            end else begin
              w_nextState = GAP;
              w_nextCount = GAP_LOAD;
            end
          end else begin
            w_nextCount = r_count - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_count == '0) begin
            w_nextState = IDLE;
          end else begin
            w_nextCount = r_count - CNT_W'(1);
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end
      endcase
    end
  end

  // Decode the code that will be live next cycle so the strobe is registered.
  dec3to8 u_dec (
    .i_code   (w_nextCode),
    .i_en     (w_nextState == PULSE),
    .o_onehot (w_onehot)
  );

  // State, counter, latched code and registered strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_code     <= 3'd0;
      r_out      <= 8'h00;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_count    <= w_nextCount;
      r_code     <= w_nextCode;
      r_out      <= w_onehot;
      r_outValid <= |w_onehot;
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == PULSE) && (r_count == '0);

endmodule
